phase_to_sincos: RTL and testbench

PHASE_TO_SINCOS -- requirements
Module: phase_to_sincos

---
 rtl/phase_to_sincos_pkg.sv | 25 ++
 rtl/phase_to_sincos_if.sv | 24 ++
 rtl/phase_to_sincos_quarter_rom.sv | 31 +++
 rtl/phase_to_sincos.sv | 135 +++++++++++++
 tb/tb_phase_to_sincos.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_to_sincos_pkg.sv
// rtl/phase_to_sincos_pkg.sv - shared constants and quarter-wave table generator for phase_to_sincos
package phase_to_sincos_pkg;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shifted towards the MSB
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam real PI_HALF = 1.5707963267948966;

  // Half-LSB offset keeps every entry positive and makes T[~a] the exact mirror of T[a]
  function automatic logic [31:0] quarter_sine_entry(input int k, input int addr_width,
                                                     input int out_width);
    real amp;
    real ang;
    amp = real'((1 << (out_width - 1)) - 1);
    ang = PI_HALF * (real'(k) + 0.5) / real'(1 << addr_width);
    return 32'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

endpackage

// File: rtl/phase_to_sincos_if.sv
// rtl/phase_to_sincos_if.sv - phase input stream and sin/cos output stream bundle
interface phase_to_sincos_if #(
  parameter int PHASE_WIDTH = 16,
  parameter int OUT_WIDTH   = 16
);
  logic [PHASE_WIDTH-1:0] i_tdata;
  logic                   i_tlast;
  logic                   i_tvalid;
  logic                   i_tready;
  logic [2*OUT_WIDTH-1:0] o_tdata;
  logic                   o_tlast;
  logic                   o_tvalid;
  logic                   o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/phase_to_sincos_quarter_rom.sv
// rtl/phase_to_sincos_quarter_rom.sv - dual-read synchronous quarter-wave sine ROM
module sincos_quarter_rom
  import phase_to_sincos_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [OUT_WIDTH-2:0]  data_a,
  output logic [OUT_WIDTH-2:0]  data_b
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [OUT_WIDTH-2:0] table_mem [DEPTH];

  // Entries are magnitudes only; the sign bit is restored by the fold stage
  for (genvar k = 0; k < DEPTH; k++) begin : g_table
    localparam logic [31:0] ENTRY = quarter_sine_entry(k, ADDR_WIDTH, OUT_WIDTH);
    assign table_mem[k] = ENTRY[OUT_WIDTH-2:0];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= table_mem[addr_a];
      data_b <= table_mem[addr_b];
    end
  end
endmodule

// File: rtl/phase_to_sincos.sv
// rtl/phase_to_sincos.sv - 3-stage phase to sin/cos streaming converter with quarter-wave folding
// Build option: PHASE_TO_SINCOS_DITHER_EN adds LFSR phase dither ahead of truncation.
module phase_to_sincos
  import phase_to_sincos_pkg::*;
#(
  parameter int PHASE_WIDTH    = 16,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int OUT_WIDTH      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  phase_to_sincos_if.slave   bus
);
  localparam int DITHER_W = PHASE_WIDTH - 2 - LUT_ADDR_WIDTH;

  logic flush;
  logic en;
  logic accept;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] unused_phase;

  assign flush        = reset | clear;
  assign en           = bus.o_tready | ~bus.o_tvalid;
  assign bus.i_tready = en;
  assign accept       = bus.i_tvalid & en;

`ifdef PHASE_TO_SINCOS_DITHER_EN
  logic [15:0]            lfsr;
  logic [PHASE_WIDTH-1:0] dither;

  always_ff @(posedge clk) begin
    if (flush) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  // Only the bits that truncation would drop are dithered
  always_comb begin
    dither = '0;
    for (int i = 0; i < DITHER_W && i < 16; i++) begin
      dither[i] = lfsr[i];
    end
  end

  assign phase = bus.i_tdata + dither;
`else
  assign phase = bus.i_tdata;
`endif

  assign unused_phase = phase;

  logic                      s1_valid;
  logic                      s1_last;
  logic [1:0]                s1_quad;
  logic [LUT_ADDR_WIDTH-1:0] s1_addr;

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_quad  <= '0;
      s1_addr  <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_last  <= bus.i_tlast;
      s1_quad  <= phase[PHASE_WIDTH-1 -: 2];
      s1_addr  <= phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    end
  end

  logic [OUT_WIDTH-2:0] rom_a;
  logic [OUT_WIDTH-2:0] rom_b;
  logic                 s2_valid;
  logic                 s2_last;
  logic [1:0]           s2_quad;

  sincos_quarter_rom #(
    .ADDR_WIDTH (LUT_ADDR_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_rom (
    .clk    (clk),
    .en     (en),
    .addr_a (s1_addr),
    .addr_b (~s1_addr),
    .data_a (rom_a),
    .data_b (rom_b)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_quad  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_quad  <= s1_quad;
    end
  end

  logic signed [OUT_WIDTH-1:0] t_a;
  logic signed [OUT_WIDTH-1:0] t_b;
  logic signed [OUT_WIDTH-1:0] sin_val;
  logic signed [OUT_WIDTH-1:0] cos_val;

  assign t_a = signed'({1'b0, rom_a});
  assign t_b = signed'({1'b0, rom_b});

  // Table magnitudes never reach the negative full-scale code, so negation cannot wrap
  always_comb begin
    sin_val = t_a;
    cos_val = t_b;
    case (s2_quad)
      QUAD_0: begin sin_val = t_a;  cos_val = t_b;  end
      QUAD_1: begin sin_val = t_b;  cos_val = -t_a; end
      QUAD_2: begin sin_val = -t_a; cos_val = -t_b; end
      QUAD_3: begin sin_val = -t_b; cos_val = t_a;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      bus.o_tvalid <= 1'b0;
      bus.o_tlast  <= 1'b0;
      bus.o_tdata  <= '0;
    end else if (en) begin
      bus.o_tvalid <= s2_valid;
      bus.o_tlast  <= s2_last;
      bus.o_tdata  <= {cos_val, sin_val};
    end
  end
endmodule

// File: tb/tb_phase_to_sincos.sv
// tb/tb_phase_to_sincos.sv - self-checking bench for phase_to_sincos (default build)
module tb_phase_to_sincos;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  phase_to_sincos_if #(.PHASE_WIDTH(16), .OUT_WIDTH(16)) bus ();

  phase_to_sincos #(
    .PHASE_WIDTH    (16),
    .LUT_ADDR_WIDTH (10),
    .OUT_WIDTH      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] phase;
    logic        last;
  } beat_t;

  int    checks    = 0;
  int    fails     = 0;
  int    out_count = 0;
  beat_t exp_q[$];

  logic        stall_prev = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  beat_t       e_beat;
  int          s_val;
  int          c_val;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    int d;
    checks++;
    d = act - exp;
    if (d > 1 || d < -1) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    end
  endtask

  // Ideal sample at the centre of the table bin that the phase falls into
  function automatic int ideal(input int idx, input bit want_cos);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 4096.0;
    v = 32767.0 * (want_cos ? $cos(ang) : $sin(ang));
    if (v < 0.0) return -$rtoi(-v + 0.5);
    return $rtoi(v + 0.5);
  endfunction

  always @(negedge clk) begin
    if (reset || clear) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (bus.o_tvalid && stall_prev) begin
        chk("stall_tdata", bus.o_tdata, prev_data);
        chk("stall_tlast", bus.o_tlast, prev_last);
      end
      if (bus.o_tvalid && bus.o_tready) begin
        out_count++;
        s_val = int'($signed(bus.o_tdata[15:0]));
        c_val = int'($signed(bus.o_tdata[31:16]));
        if (exp_q.size() == 0) begin
          chk("extra_output_beat", 1, 0);
        end else begin
          e_beat = exp_q.pop_front();
          chk_near("model_sin", s_val, ideal(int'(e_beat.phase >> 4), 1'b0));
          chk_near("model_cos", c_val, ideal(int'(e_beat.phase >> 4), 1'b1));
          chk("model_tlast", bus.o_tlast, e_beat.last);
          chk("sin_not_min", s_val == -32768, 0);
          chk("cos_not_min", c_val == -32768, 0);
        end
      end
      if (bus.i_tvalid && bus.i_tready) begin
        exp_q.push_back('{phase: bus.i_tdata, last: bus.i_tlast});
      end
      stall_prev = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
      prev_last  = bus.o_tlast;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was taken
  task automatic send(input logic [15:0] ph, input logic last);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.i_tdata  = ph;
    bus.i_tlast  = last;
    bus.i_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.i_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  int          ph_tab  [4] = '{32'h0000, 32'h4000, 32'h8000, 32'hC000};
  int          sin_tab [4] = '{25, 32767, -25, -32767};
  int          cos_tab [4] = '{32767, -25, -32767, 25};
  int          base;
  logic [31:0] pv;

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_tvalid", bus.o_tvalid, 0);
    chk("reset_tdata", bus.o_tdata, 0);
    chk("reset_tlast", bus.o_tlast, 0);
    chk("ready_after_reset", bus.i_tready, 1);
    @(posedge clk);
    #1;

    // Quadrant corners back-to-back: three-cycle latency, one result per cycle
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        bus.i_tvalid = 1'b1;
        pv = ph_tab[k];
        bus.i_tdata = pv[15:0];
      end else begin
        bus.i_tvalid = 1'b0;
      end
      @(negedge clk);
      chk("latency_tvalid", bus.o_tvalid, (k >= 3 && k <= 6) ? 1 : 0);
      if (k >= 3 && k <= 6) begin
        chk("corner_sin", int'($signed(bus.o_tdata[15:0])), sin_tab[k-3]);
        chk("corner_cos", int'($signed(bus.o_tdata[31:16])), cos_tab[k-3]);
      end
      @(posedge clk);
      #1;
    end

    // Full phase sweep at one beat per cycle
    base = out_count;
    for (int p = 0; p < 65536; p++) begin
      pv = p;
      send(pv[15:0], p == 65535);
    end
    drain();
    chk("sweep_count", out_count - base, 65536);

    // Eight beats with alternating back-pressure
    base = out_count;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          pv = 32'h1000 * k + 32'h0123;
          send(pv[15:0], k == 7);
        end
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1 bus.o_tready = ~bus.o_tready;
        end
      end
    join
    bus.o_tready = 1'b1;
    drain();
    chk("toggle_count", out_count - base, 8);

    // Fill the pipeline under a long stall, then release
    base = out_count;
    bus.o_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pv = 32'h2345 + 32'h3000 * k;
      send(pv[15:0], 1'b0);
    end
    bus.i_tvalid = 1'b1;
    bus.i_tdata  = 16'h7777;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall_i_tready", bus.i_tready, 0);
      chk("stall_o_tvalid", bus.o_tvalid, 1);
      @(posedge clk);
      #1;
    end
    bus.o_tready = 1'b1;
    send(16'h7777, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pv = 32'h9abc + 32'h1111 * k;
      send(pv[15:0], k == 3);
    end
    drain();
    chk("stall_release_count", out_count - base, 8);

    // Clear with three beats in flight
    bus.o_tready = 1'b0;
    send(16'h1234, 1'b1);
    send(16'h5678, 1'b0);
    send(16'h9abc, 1'b0);
    base = out_count;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clear_tvalid", bus.o_tvalid, 0);
    chk("clear_tdata", bus.o_tdata, 0);
    chk("clear_tlast", bus.o_tlast, 0);
    @(posedge clk);
    #1 bus.o_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("clear_discarded", out_count - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
